uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, LSB first, registered line.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_read,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  tx_d;
  logic                  bit_end;
  logic                  load;
  logic                  done;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign bit_end     = (cnt_q == CNT_LAST);
  assign o_fifo_read = load & i_rst_n;
  assign o_busy      = (state_q != IDLE);
  assign o_tx_done   = done;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!i_fifo_empty) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (idx_q == BIT_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STP_LAST) begin
            done  = 1'b1;
            idx_d = '0;
            // chain straight into the next frame when a word is waiting
            if (!i_fifo_empty) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load) sh_d = i_fifo_data;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    if (load) par_d = ^i_fifo_data;
`endif

    // line level follows the state being entered, so o_tx is a plain flop
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      o_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      o_tx    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench against a bit-list line model.
// Runs one-stop-bit and two-stop-bit instances side by side.
module tb_uart_tx_fifo;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_req;
  logic [1:0] empty;
  logic [1:0] rd, tx, busy, done;
  logic [7:0] fdata [2];

  logic [7:0] fq [2][$];
  bit         line [2][$];
  bit         chk;
  int         vectors;
  int         miscompares;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(1)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fifo_empty(empty[0]), .i_fifo_data(fdata[0]),
    .o_fifo_read(rd[0]), .o_tx(tx[0]),
    .o_busy(busy[0]), .o_tx_done(done[0])
  );

  uart_tx_fifo #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(2)
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fifo_empty(empty[1]), .i_fifo_data(fdata[1]),
    .o_fifo_read(rd[1]), .o_tx(tx[1]),
    .o_busy(busy[1]), .o_tx_done(done[1])
  );

  function automatic int frame_len(int k);
    return C * (1 + 8 + PAR + k + 1);
  endfunction

  // expected line level for every cycle of one frame
  function automatic void push_frame(int k, logic [7:0] w);
    repeat (C) line[k].push_back(1'b0);
    for (int i = 0; i < 8; i++)
      repeat (C) line[k].push_back(w[i]);
`ifdef UART_TX_PARITY_EN
    repeat (C) line[k].push_back(^w);
`endif
    repeat (C * (k + 1)) line[k].push_back(1'b1);
  endfunction

  task automatic tick();
    logic [1:0] ep;
    @(negedge clk);
    rst_n = rst_req;
    for (int k = 0; k < 2; k++) begin
      empty[k] = (fq[k].size() == 0);
      ep[k] = rst_n && !empty[k] && line[k].size() <= 1;
      fdata[k] = ep[k] ? fq[k][0] : 8'($urandom);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      if (chk) begin
        logic e_tx, e_busy, e_done;
        e_tx   = (line[k].size() != 0) ? line[k][0] : 1'b1;
        e_busy = (line[k].size() != 0);
        e_done = (line[k].size() == 1);
        vectors += 4;
        if (tx[k] !== e_tx) begin
          miscompares++;
          $display("FAIL tx%0d t=%0t got %b exp %b",
                   k, $time, tx[k], e_tx);
        end
        if (busy[k] !== e_busy) begin
          miscompares++;
          $display("FAIL busy%0d t=%0t got %b exp %b",
                   k, $time, busy[k], e_busy);
        end
        if (done[k] !== e_done) begin
          miscompares++;
          $display("FAIL done%0d t=%0t got %b exp %b",
                   k, $time, done[k], e_done);
        end
        if (rd[k] !== ep[k]) begin
          miscompares++;
          $display("FAIL read%0d t=%0t got %b exp %b",
                   k, $time, rd[k], ep[k]);
        end
      end
      if (!rst_n) begin
        line[k].delete();
      end else begin
        if (line[k].size() != 0) void'(line[k].pop_front());
        if (ep[k]) push_frame(k, fq[k].pop_front());
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fq[0].size() + fq[1].size() +
            line[0].size() + line[1].size()) != 0 &&
           n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain timeout got %0d cycles exp <%0d",
               n, budget);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_req = 1'b0;
    chk = 1'b0;
    tick();
    tick();
    chk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int bn0, bn1, dn, pops;
    bn0 = 0; bn1 = 0; dn = 0; pops = 0;
    fq[0].push_back(8'hA5);
    fq[1].push_back(8'h55);
    rst_req = 1'b1;
    repeat (70) begin
      tick();
      bn0 += int'(busy[0]);
      bn1 += int'(busy[1]);
      dn += int'(done[0]);
      pops += int'(rd[0]);
    end
    vectors += 4;
    if (bn0 != C * (10 + PAR)) begin
      miscompares++;
      $display("FAIL single_len got %0d exp %0d", bn0, C * (10 + PAR));
    end
    if (bn1 != C * (11 + PAR)) begin
      miscompares++;
      $display("FAIL stop2_len got %0d exp %0d", bn1, C * (11 + PAR));
    end
    if (dn != 1) begin
      miscompares++;
      $display("FAIL single_done got %0d exp 1", dn);
    end
    if (pops != 1) begin
      miscompares++;
      $display("FAIL single_pops got %0d exp 1", pops);
    end
  endtask

  task automatic test_idle();
    repeat (100) tick();
  endtask

  task automatic test_back_to_back();
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    fq[0].push_back(8'h00);
    fq[0].push_back(8'hFF);
    fq[1].push_back(8'($urandom));
    fq[1].push_back(8'($urandom));
    for (int t = 0; t < 120; t++) begin
      tick();
      if (busy[0]) begin
        if (first < 0) first = t;
        last = t;
        cnt++;
      end
    end
    vectors += 2;
    if (cnt != 2 * frame_len(0)) begin
      miscompares++;
      $display("FAIL b2b_busy got %0d exp %0d", cnt, 2 * frame_len(0));
    end
    if (last - first + 1 != 2 * frame_len(0)) begin
      miscompares++;
      $display("FAIL b2b_gap got span %0d exp %0d",
               last - first + 1, 2 * frame_len(0));
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      fq[k].push_back(8'($urandom));
      fq[k].push_back(8'($urandom));
    end
    repeat (19) tick();
    rst_req = 1'b0;
    tick();
    rst_req = 1'b1;
    tick();
    vectors += 2;
    if (tx[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_tx got %b exp 1", tx[0]);
    end
    if (busy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_busy got %b exp 0", busy[0]);
    end
    drain(1000);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 2; k++)
        repeat ($urandom_range(0, 3))
          fq[k].push_back(8'($urandom));
      repeat ($urandom_range(0, 60)) tick();
    end
    drain(3000);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_req = 1'b0;
    rst_n = 1'b0;
    empty = 2'b11;
    fdata[0] = 8'h00;
    fdata[1] = 8'h00;
    chk = 1'b0;
    test_reset();
    test_single();
    test_idle();
    test_back_to_back();
    drain(500);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
